fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Purpose: shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // Opcode nibble that stops the fetch stream.
  localparam logic [3:0] HALT_OPCODE = 4'hF;
  localparam int         OPC_LSB     = 28;
  localparam int         OPC_W       = 4;

  // Low bit of each register-address field inside an instruction word.
  localparam int RD_LSB = 24;
  localparam int RS_LSB = 20;
  localparam int RX_LSB = 16;
  localparam int RK_LSB = 12;

endpackage

// File: rtl/fetch_unit.sv
// Purpose: sequential instruction fetch with branch redirect and HALT detection.
// Latency: instr/PCo/instr_valid update 1 cycle after imem_ack; one instr per cycle on zero-wait memory.
// Backpressure: stall holds a valid instr and suppresses imem_req; branch_taken overrides stall.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       downstream not ready
//   branch_taken/branch_target  redirect request and address
//   imem_req/imem_addr          fetch request and address to instruction memory
//   imem_ack/imem_rdata         memory response (only honoured while imem_req=1)
//   instr/instr_valid/PCo       registered instruction, its valid flag and its address
//   RD/RS/RX/RK                 register-address fields sliced from instr
//   halted                      HALT instruction has been captured
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int             BUS      = 32,
  parameter int             DIR      = 4,
  parameter logic [BUS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [BUS-1:0] branch_target,
  output logic           imem_req,
  output logic [BUS-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [BUS-1:0] imem_rdata,
  output logic [BUS-1:0] instr,
  output logic           instr_valid,
  output logic [BUS-1:0] PCo,
  output logic [DIR-1:0] RD,
  output logic [DIR-1:0] RS,
  output logic [DIR-1:0] RX,
  output logic [DIR-1:0] RK,
  output logic           halted
);

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [BUS-1:0] pc;
  logic           redirect;
  logic           capture;
  logic           consume;
  logic           rdata_is_halt;

  // A held (stalled) instruction blocks new requests; an unstalled one can be
  // replaced in the same cycle, giving back-to-back fetches.
  assign imem_req  = (state == ST_FETCH) && !(instr_valid && stall);
  assign imem_addr = pc;

  // HALT is terminal: redirects are ignored there.
  assign redirect      = branch_taken && (state != ST_HALT);
  assign capture       = imem_req && imem_ack && !redirect;
  assign consume       = instr_valid && !stall;
  assign rdata_is_halt = (imem_rdata[OPC_LSB +: OPC_W] == HALT_OPCODE);

  assign halted = (state == ST_HALT);

  assign RD = instr[RD_LSB +: DIR];
  assign RS = instr[RS_LSB +: DIR];
  assign RX = instr[RX_LSB +: DIR];
  assign RK = instr[RK_LSB +: DIR];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  state_nxt = ST_FETCH;
      ST_FETCH: if (capture && rdata_is_halt) state_nxt = ST_HALT;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      PCo         <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        // Any response arriving with the redirect belongs to the old stream.
        pc          <= branch_target;
        instr_valid <= 1'b0;
      end else if (capture) begin
        instr       <= imem_rdata;
        PCo         <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + BUS'(4);
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
